// File: rtl/div_proto_pkg.sv
// Byte-serial divide protocol: frame geometry, FSM encoding and byte positions.
// Shared by the initiator (div_client) and the responder control block.
package div_proto_pkg;

    localparam int FRAME_BYTES = 4;
    localparam int TIMER_W     = 20;

    typedef logic [1:0] byte_idx_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_RECV = 2'd2;
    localparam logic [1:0] ST_FIN  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_SEND = ST_SEND,
        S_RECV = ST_RECV,
        S_FIN  = ST_FIN
    } state_t;

    // Request frame: dividend then divisor, MSB first.
    localparam byte_idx_t REQ_A_HI = 2'd0;
    localparam byte_idx_t REQ_A_LO = 2'd1;
    localparam byte_idx_t REQ_B_HI = 2'd2;
    localparam byte_idx_t REQ_B_LO = 2'd3;

    // Response frame: quotient then remainder, MSB first.
    localparam byte_idx_t RSP_Y_HI = 2'd0;
    localparam byte_idx_t RSP_Y_LO = 2'd1;
    localparam byte_idx_t RSP_R_HI = 2'd2;
    localparam byte_idx_t RSP_R_LO = 2'd3;

    localparam byte_idx_t LAST_IDX = byte_idx_t'(FRAME_BYTES - 1);

endpackage

// File: rtl/frame_timer.sv
// Inter-byte timeout counter: clear has priority over enable; expired flags MAX-1.
// Latency: expired is a combinational decode of the registered count.
// Backpressure: none; the owner leaves the counting state on expiry, so it never wraps.
module frame_timer #(
    parameter int MAX = 500000,
    parameter int W   = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

    assign expired = (count == W'(MAX - 1));

endmodule

// File: rtl/div_client.sv
// Divide initiator: ships {a,b} as a 4-byte frame to UART TX, gathers {y,r} from UART RX.
// Latency: start -> done = 1 + request cycles + response arrival + 1.
// Backpressure: tx_data held while tx_ready=0; rx has none, a silent responder trips the timeout.
module div_client
    import div_proto_pkg::*;
#(
    parameter int TIMEOUT_MAX = 500000,
    parameter int DATA_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] y_out,
    output logic [DATA_W-1:0] r_out,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data
);

    state_t            state, state_nxt;
    byte_idx_t         idx;
    logic [DATA_W-1:0] a_q, b_q;
    logic [23:0]       rsp_sh;
    logic              err_q;
    logic              tmr_clr, tmr_en, tmr_expired;
    logic              last_tx, last_rx;

    assign last_tx = (state == S_SEND) && tx_ready && (idx == LAST_IDX);
    assign last_rx = (state == S_RECV) && rx_valid && (idx == LAST_IDX);
    assign tmr_clr = last_tx || ((state == S_RECV) && rx_valid);
    assign tmr_en  = (state == S_RECV);

    frame_timer #(
        .MAX (TIMEOUT_MAX),
        .W   (TIMER_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_SEND;
            end
            S_SEND: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                case (idx)
                    REQ_A_HI: tx_data = a_q[15:8];
                    REQ_A_LO: tx_data = a_q[7:0];
                    REQ_B_HI: tx_data = b_q[15:8];
                    REQ_B_LO: tx_data = b_q[7:0];
                    default:  tx_data = 8'h00;
                endcase
                if (last_tx) state_nxt = S_RECV;
            end
            S_RECV: begin
                busy = 1'b1;
                // An arriving byte beats an expiring timer in the same cycle.
                if (last_rx) begin
                    state_nxt = S_FIN;
                end else if (!rx_valid && tmr_expired) begin
                    state_nxt = S_FIN;
                end
            end
            S_FIN: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign err = done && err_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_q    <= '0;
            b_q    <= '0;
            idx    <= '0;
            rsp_sh <= '0;
            err_q  <= 1'b0;
            y_out  <= '0;
            r_out  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q <= a_in;
                        b_q <= b_in;
                        idx <= '0;
                    end
                end
                S_SEND: begin
                    // Wraps 3 -> 0 on the last byte, ready for the response.
                    if (tx_ready) idx <= idx + byte_idx_t'(1);
                end
                S_RECV: begin
                    if (rx_valid) begin
                        rsp_sh <= {rsp_sh[15:0], rx_data};
                        idx    <= idx + byte_idx_t'(1);
                        if (idx == LAST_IDX) begin
                            y_out <= rsp_sh[23:8];
                            r_out <= {rsp_sh[7:0], rx_data};
                            err_q <= 1'b0;
                        end
                    end else if (tmr_expired) begin
                        err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
